// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e  : arbiter FSM state encoding
//   TIMEOUT_DATA : word returned to the requester when an access is aborted
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arb_state_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the pipeline-side and memory-side signals of the port arbiter.
//   Fetch   : if_req, if_addr -> if_rdata, if_valid
//   MEM     : MemtoRegM, MemWriteM, ALUOutM, WriteDataM -> ReadDataM, d_valid
//   Control : stall, timeout_err
//   Memory  : mem_req, mem_we, mem_addr, mem_wdata <- mem_ack, mem_rdata
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding pipeline and memory (environment view)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;

  logic        MemtoRegM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        d_valid;

  logic        stall;
  logic        timeout_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, mem_ack, mem_rdata,
    output if_rdata, if_valid, ReadDataM, d_valid, stall, timeout_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, mem_ack, mem_rdata,
    input  if_rdata, if_valid, ReadDataM, d_valid, stall, timeout_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles an access has been waiting for its acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at 0 (access being launched)
//   run        : a cycle spent waiting without acknowledge
//   expired    : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_cnt;

  assign expired = (r_cnt == Limit);

  // Holds at the limit so the count never wraps before the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the MEM stage.
// Data accesses win over fetches (older instruction). The pipeline is stalled
// until every access requested in the current cycle has completed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (pipeline + memory handshake)
//   stall_cycles, timeout_cnt : performance counters, only with PERF_CNT_EN
// Configuration macro: PERF_CNT_EN (adds the performance counter outputs).
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [7:0]          timeout_cnt
`endif
);

  arb_state_e  r_state, w_state_d;
  logic        r_d_done, w_d_done_d;
  logic        r_i_done, w_i_done_d;
  logic        r_timeout_err, w_timeout_err_d;
  logic        r_mem_req, w_mem_req_d;
  logic        r_mem_we, w_mem_we_d;
  logic [31:0] r_mem_addr, w_mem_addr_d;
  logic [31:0] r_mem_wdata, w_mem_wdata_d;
  logic [31:0] r_read_data, w_read_data_d;
  logic [31:0] r_if_rdata, w_if_rdata_d;

  logic        w_dreq;
  logic        w_stall;
  logic        w_start_data;
  logic        w_start_inst;
  logic        w_busy;
  logic        w_ack;
  logic        w_abort;
  logic        w_expired;
  logic [31:0] w_cap_data;

  // Both MemtoRegM and MemWriteM high is illegal; MemWriteM then selects a write.
  assign w_dreq  = bus.MemtoRegM | bus.MemWriteM;
  assign w_stall = (w_dreq & ~r_d_done) | (bus.if_req & ~r_i_done);

  assign w_start_data = (r_state == IDLE) & w_dreq & ~r_d_done;
  assign w_start_inst = (r_state == IDLE) & ~w_start_data & bus.if_req & ~r_i_done;

  assign w_busy  = (r_state != IDLE);
  // Ack takes priority over an expiring timer in the same cycle.
  assign w_ack   = w_busy & bus.mem_ack;
  assign w_abort = w_busy & ~bus.mem_ack & w_expired;

  assign w_cap_data = w_ack ? bus.mem_rdata : TIMEOUT_DATA;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_start_data | w_start_inst),
    .run     (w_busy & ~bus.mem_ack),
    .expired (w_expired)
  );

  always_comb begin
    w_state_d       = r_state;
    w_d_done_d      = r_d_done;
    w_i_done_d      = r_i_done;
    w_timeout_err_d = r_timeout_err;
    w_mem_req_d     = r_mem_req;
    w_mem_we_d      = r_mem_we;
    w_mem_addr_d    = r_mem_addr;
    w_mem_wdata_d   = r_mem_wdata;
    w_read_data_d   = r_read_data;
    w_if_rdata_d    = r_if_rdata;

    unique case (r_state)
      IDLE: begin
        if (w_start_data) begin
          w_state_d     = DATA;
          w_mem_req_d   = 1'b1;
          w_mem_we_d    = bus.MemWriteM;
          w_mem_addr_d  = bus.ALUOutM;
          w_mem_wdata_d = bus.WriteDataM;
        end else if (w_start_inst) begin
          w_state_d     = INST;
          w_mem_req_d   = 1'b1;
          w_mem_we_d    = 1'b0;
          w_mem_addr_d  = bus.if_addr;
          w_mem_wdata_d = 32'h0;
        end
      end
      DATA: begin
        if (w_ack || w_abort) begin
          w_state_d   = IDLE;
          w_mem_req_d = 1'b0;
          w_d_done_d  = 1'b1;
          if (!r_mem_we) begin
            w_read_data_d = w_cap_data;
          end
        end
      end
      INST: begin
        if (w_ack || w_abort) begin
          w_state_d    = IDLE;
          w_mem_req_d  = 1'b0;
          w_i_done_d   = 1'b1;
          w_if_rdata_d = w_cap_data;
        end
      end
      default: begin
        w_state_d   = IDLE;
        w_mem_req_d = 1'b0;
      end
    endcase

    if (w_abort) begin
      w_timeout_err_d = 1'b1;
    end

    // Pipeline advances: a result landing now belongs to a withdrawn request and
    // must not mark the next instruction's access as done.
    if (!w_stall) begin
      w_d_done_d = 1'b0;
      w_i_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_d_done      <= 1'b0;
      r_i_done      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'h0;
      r_mem_wdata   <= 32'h0;
      r_read_data   <= 32'h0;
      r_if_rdata    <= 32'h0;
    end else begin
      r_state       <= w_state_d;
      r_d_done      <= w_d_done_d;
      r_i_done      <= w_i_done_d;
      r_timeout_err <= w_timeout_err_d;
      r_mem_req     <= w_mem_req_d;
      r_mem_we      <= w_mem_we_d;
      r_mem_addr    <= w_mem_addr_d;
      r_mem_wdata   <= w_mem_wdata_d;
      r_read_data   <= w_read_data_d;
      r_if_rdata    <= w_if_rdata_d;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.d_valid     = r_d_done;
  assign bus.if_valid    = r_i_done;
  assign bus.ReadDataM   = r_read_data;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.timeout_err = r_timeout_err;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [7:0]  r_timeout_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'h0;
      r_timeout_cnt  <= 8'h0;
    end else begin
      if (w_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_abort && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign timeout_cnt  = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 16).
// Memory acknowledges are driven by hand in each step.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n;

  mem_port_arbiter_if bus ();

`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [7:0]  timeout_cnt;
  logic [31:0] base_stall;
  int          seen_stall;
`endif

  mem_port_arbiter #(
    .TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .timeout_cnt  (timeout_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'h0;
    bus.MemtoRegM  = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.ALUOutM    = 32'h0;
    bus.WriteDataM = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rdata", bus.ReadDataM, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_valids", {bus.d_valid, bus.if_valid}, 0);
    rst_n = 1'b1;
    step();

    // 1: load at 0x40, ack on first request cycle
    bus.MemtoRegM = 1'b1;
    bus.ALUOutM   = 32'h40;
    #1;
    chk("t1_stall_c0", bus.stall, 1);
    chk("t1_req_c0", bus.mem_req, 0);
    step();
    chk("t1_req", bus.mem_req, 1);
    chk("t1_we", bus.mem_we, 0);
    chk("t1_addr", bus.mem_addr, 32'h40);
    chk("t1_stall_c1", bus.stall, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    step();
    bus.mem_ack = 1'b0;
    chk("t1_req_drop", bus.mem_req, 0);
    chk("t1_stall_rel", bus.stall, 0);
    chk("t1_dvalid", bus.d_valid, 1);
    chk("t1_rdata", bus.ReadDataM, 32'hCAFE_0001);
    bus.MemtoRegM = 1'b0;
    step();
    chk("t1_dvalid_clr", bus.d_valid, 0);

    // 2: store and fetch together, ack on second request cycle each
    bus.MemWriteM  = 1'b1;
    bus.ALUOutM    = 32'h80;
    bus.WriteDataM = 32'h1234_5678;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h100;
    step();
    chk("t2_we", bus.mem_we, 1);
    chk("t2_addr", bus.mem_addr, 32'h80);
    chk("t2_wdata", bus.mem_wdata, 32'h1234_5678);
    step();
    chk("t2_req_hold", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ack = 1'b0;
    chk("t2_store_nocap", bus.ReadDataM, 32'hCAFE_0001);
    chk("t2_dvalid", bus.d_valid, 1);
    chk("t2_stall_fetch", bus.stall, 1);
    chk("t2_req_gap", bus.mem_req, 0);
    step();
    chk("t2_ireq", bus.mem_req, 1);
    chk("t2_iwe", bus.mem_we, 0);
    chk("t2_iaddr", bus.mem_addr, 32'h100);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_ack = 1'b0;
    chk("t2_stall_rel", bus.stall, 0);
    chk("t2_ivalid", bus.if_valid, 1);
    chk("t2_if_rdata", bus.if_rdata, 32'h0000_0013);
    bus.MemWriteM = 1'b0;
    bus.if_req    = 1'b0;
    step();
    chk("t2_flags_clr", {bus.d_valid, bus.if_valid}, 0);

    // 5: MemtoRegM and MemWriteM both set -> write, ReadDataM untouched
    bus.MemtoRegM  = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.ALUOutM    = 32'hC0;
    bus.WriteDataM = 32'hA5A5_A5A5;
    step();
    chk("t5_we", bus.mem_we, 1);
    chk("t5_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.mem_ack = 1'b0;
    chk("t5_rdata_keep", bus.ReadDataM, 32'hCAFE_0001);
    chk("t5_dvalid", bus.d_valid, 1);
    bus.MemtoRegM = 1'b0;
    bus.MemWriteM = 1'b0;
    step();

    // Ack arriving exactly at the timeout limit wins
    bus.MemtoRegM = 1'b1;
    bus.ALUOutM   = 32'h48;
    step();
    repeat (15) step();
    chk("lim_req_hold", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    bus.mem_ack = 1'b0;
    chk("lim_rdata", bus.ReadDataM, 32'h5555_AAAA);
    chk("lim_no_terr", bus.timeout_err, 0);
    bus.MemtoRegM = 1'b0;
    step();

    // 3: fetch never acknowledged -> abort after 16 request cycles
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    step();
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      step();
    end
    chk("t3_req_cycles", n, 16);
    chk("t3_if_rdata", bus.if_rdata, 32'h0);
    chk("t3_terr", bus.timeout_err, 1);
    chk("t3_ivalid", bus.if_valid, 1);
    bus.if_req = 1'b0;
    step();
    step();
    chk("t3_terr_sticky", bus.timeout_err, 1);

    // 4: reset while a data access is in flight
    bus.MemtoRegM = 1'b1;
    bus.ALUOutM   = 32'h44;
    step();
    chk("t4_req_pre", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_req_async", bus.mem_req, 0);
    chk("t4_terr_clr", bus.timeout_err, 0);
    bus.MemtoRegM = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t4_stall_idle", bus.stall, 0);
    chk("t4_req_idle", bus.mem_req, 0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    #1;
    chk("t4_stall_fresh", bus.stall, 1);
    step();
    chk("t4_iaddr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    step();
    bus.mem_ack = 1'b0;
    chk("t4_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.if_req = 1'b0;
    step();

`ifdef PERF_CNT_EN
    // 6: three back-to-back loads, ack on second request cycle
    chk("t6_tocnt", timeout_cnt, 0);
    base_stall = stall_cycles;
    seen_stall = 0;
    for (int l = 0; l < 3; l++) begin
      bus.MemtoRegM = 1'b1;
      bus.ALUOutM   = 32'h400 + 32'(l * 4);
      #1;
      seen_stall += int'(bus.stall);
      step();
      seen_stall += int'(bus.stall);
      step();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h100 + 32'(l);
      seen_stall += int'(bus.stall);
      step();
      bus.mem_ack = 1'b0;
      bus.MemtoRegM = 1'b0;
      step();
    end
    chk("t6_seen", seen_stall, 9);
    chk("t6_stall_cycles", stall_cycles - base_stall, 9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
